cmp8_serial_loader: RTL and testbench

- Upstream feeder for the 8-bit cascaded comparator (cmp8).
- Assembles two operands that arrive serially, one bit per valid cycle on two lines.
- Presents the operands in parallel, together with the cascade seed inputs, to cmp8.
- Captures cmp8's EQ/GT outcome into registered result flags and holds them behind a done/ack handshake.

---
 rtl/cmp8_serial_loader_if.sv | 41 ++++
 rtl/cmp8_serial_loader.sv | 135 +++++++++++++
 tb/tb_cmp8_serial_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cmp8_serial_loader_if.sv
// Purpose : bundles the loader's serial input, cmp8 return path, parallel operand and result signals.
// Latency : n/a (signal bundle only).
// Backpressure: result is held behind done/res_ack; bit_valid low stalls the shift.
// Ports (slave = loader side):
//   in : start, bit_valid, ser_a, ser_b, res_ack, cmp_eq, cmp_gt
//   out: par_a, par_b, eq_seed, gt_seed, opnd_valid, busy, done, res_eq, res_gt, res_lt
interface cmp8_serial_loader_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             bit_valid;
    logic             ser_a;
    logic             ser_b;
    logic             res_ack;
    logic             cmp_eq;
    logic             cmp_gt;
    logic [WIDTH-1:0] par_a;
    logic [WIDTH-1:0] par_b;
    logic             eq_seed;
    logic             gt_seed;
    logic             opnd_valid;
    logic             busy;
    logic             done;
    logic             res_eq;
    logic             res_gt;
    logic             res_lt;

    // Loader side.
    modport slave (
        input  start, bit_valid, ser_a, ser_b, res_ack, cmp_eq, cmp_gt,
        output par_a, par_b, eq_seed, gt_seed, opnd_valid, busy, done,
               res_eq, res_gt, res_lt
    );

    // Environment side: serial source, cmp8 and result consumer.
    modport master (
        output start, bit_valid, ser_a, ser_b, res_ack, cmp_eq, cmp_gt,
        input  par_a, par_b, eq_seed, gt_seed, opnd_valid, busy, done,
               res_eq, res_gt, res_lt
    );
endinterface

// File: rtl/cmp8_serial_loader.sv
// Purpose : assembles two serial operands, presents them to cmp8, registers EQ/GT/LT.
// Latency : start + WIDTH valid bits + 1 settle cycle; done from cycle WIDTH+2 with no stalls.
// Backpressure: bit_valid low stalls SHIFT; result held in DONE until res_ack.
// Ports: clk, rst_n (async active-low) plus the slave modport of cmp8_serial_loader_if.
module cmp8_serial_loader #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cmp8_serial_loader_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_SETTLE,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] par_a_q, par_b_q;
    logic [WIDTH-1:0] par_a_nxt, par_b_nxt;
    logic             res_eq_q, res_gt_q, res_lt_q;
    logic             load_clr;
    logic             shift_en;
    logic             capture;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state / control ----------------
    always_comb begin
        state_d  = state_q;
        load_clr = 1'b0;
        shift_en = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // bit_valid in the start cycle is deliberately dropped.
                if (bus.start) begin
                    load_clr = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.bit_valid) begin
                    shift_en = 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                // cmp8 has had a full cycle on stable operands; sample it now.
                capture = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.res_ack) begin
                    if (bus.start) begin
                        load_clr = 1'b1;
                        state_d  = ST_SHIFT;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- shift direction ----------------
    always_comb begin
        if (MSB_FIRST) begin
            par_a_nxt = {par_a_q[WIDTH-2:0], bus.ser_a};
            par_b_nxt = {par_b_q[WIDTH-2:0], bus.ser_b};
        end else begin
            par_a_nxt = {bus.ser_a, par_a_q[WIDTH-1:1]};
            par_b_nxt = {bus.ser_b, par_b_q[WIDTH-1:1]};
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            par_a_q <= '0;
            par_b_q <= '0;
        end else if (load_clr) begin
            cnt_q   <= '0;
            par_a_q <= '0;
            par_b_q <= '0;
        end else if (shift_en) begin
            cnt_q   <= cnt_q + CNT_W'(1);
            par_a_q <= par_a_nxt;
            par_b_q <= par_b_nxt;
        end
    end

    // Result flags survive until the next capture; LT is derived so exactly one flag is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_eq_q <= 1'b0;
            res_gt_q <= 1'b0;
            res_lt_q <= 1'b0;
        end else if (capture) begin
            res_eq_q <= bus.cmp_eq;
            res_gt_q <= bus.cmp_gt;
            res_lt_q <= ~bus.cmp_eq & ~bus.cmp_gt;
        end
    end

    // ---------------- outputs ----------------
    assign bus.par_a      = par_a_q;
    assign bus.par_b      = par_b_q;
    assign bus.eq_seed    = 1'b1;
    assign bus.gt_seed    = 1'b0;
    assign bus.opnd_valid = (state_q == ST_SETTLE);
    assign bus.busy       = (state_q == ST_SHIFT) || (state_q == ST_SETTLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.res_eq     = res_eq_q;
    assign bus.res_gt     = res_gt_q;
    assign bus.res_lt     = res_lt_q;
endmodule

// File: tb/tb_cmp8_serial_loader.sv
// Purpose : checks an MSB-first and an LSB-first loader driven by identical serial stimulus.
// Latency : n/a (bench).
// Backpressure: exercises bit_valid stalls and the done/res_ack hold.
module tb_cmp8_serial_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, bit_valid = 1'b0, ser_a = 1'b0, ser_b = 1'b0, res_ack = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cmp8_serial_loader_if #(.WIDTH(8)) bus0 ();
    cmp8_serial_loader_if #(.WIDTH(8)) bus1 ();

    cmp8_serial_loader #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    cmp8_serial_loader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Shared stimulus; each instance gets a behavioural cmp8 on its own operands.
    assign bus0.start = start;      assign bus1.start = start;
    assign bus0.bit_valid = bit_valid; assign bus1.bit_valid = bit_valid;
    assign bus0.ser_a = ser_a;      assign bus1.ser_a = ser_a;
    assign bus0.ser_b = ser_b;      assign bus1.ser_b = ser_b;
    assign bus0.res_ack = res_ack;  assign bus1.res_ack = res_ack;
    assign bus0.cmp_eq = (bus0.par_a == bus0.par_b);
    assign bus0.cmp_gt = (bus0.par_a >  bus0.par_b);
    assign bus1.cmp_eq = (bus1.par_a == bus1.par_b);
    assign bus1.cmp_gt = (bus1.par_a >  bus1.par_b);

    logic [7:0] d_pa [2];
    logic [7:0] d_pb [2];
    logic [4:0] d_st [2];   // {eq_seed, gt_seed, opnd_valid, busy, done}
    logic [2:0] d_res[2];   // {res_eq, res_gt, res_lt}
    assign d_pa[0] = bus0.par_a;  assign d_pa[1] = bus1.par_a;
    assign d_pb[0] = bus0.par_b;  assign d_pb[1] = bus1.par_b;
    assign d_st[0] = {bus0.eq_seed, bus0.gt_seed, bus0.opnd_valid, bus0.busy, bus0.done};
    assign d_st[1] = {bus1.eq_seed, bus1.gt_seed, bus1.opnd_valid, bus1.busy, bus1.done};
    assign d_res[0] = {bus0.res_eq, bus0.res_gt, bus0.res_lt};
    assign d_res[1] = {bus1.res_eq, bus1.res_gt, bus1.res_lt};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase: 0 idle, 1 collecting bits, 2 settle, 3 result held.
    // Received bits are kept as plain numbers: v = bits read as a binary number in arrival
    // order, r = bits weighted 2^k by arrival index k.
    int ph [2] = '{0, 0};
    int cnt[2] = '{0, 0};
    int va [2] = '{0, 0};
    int vb [2] = '{0, 0};
    int ra [2] = '{0, 0};
    int rb [2] = '{0, 0};
    logic [2:0] mres[2] = '{3'b000, 3'b000};

    // Instance 0 (first bit is MSB) shows v; instance 1 (first bit is LSB) shows r pushed up
    // by the number of bits still to come.
    function automatic logic [7:0] mpar(input int i, input int k, input int v, input int r);
        logic [31:0] t;
        t = (i == 0) ? 32'(v) : 32'(r << (8 - k));
        return t[7:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                ph[i] <= 0; cnt[i] <= 0; va[i] <= 0; vb[i] <= 0; ra[i] <= 0; rb[i] <= 0;
                mres[i] <= 3'b000;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic [7:0] pa, pb;
                pa = mpar(i, cnt[i], va[i], ra[i]);
                pb = mpar(i, cnt[i], vb[i], rb[i]);
                if (ph[i] == 0 || (ph[i] == 3 && res_ack)) begin
                    if (start) begin
                        ph[i] <= 1; cnt[i] <= 0; va[i] <= 0; vb[i] <= 0; ra[i] <= 0; rb[i] <= 0;
                    end else begin
                        ph[i] <= 0;
                    end
                end else if (ph[i] == 1 && bit_valid) begin
                    va[i]  <= va[i] * 2 + int'(ser_a);
                    vb[i]  <= vb[i] * 2 + int'(ser_b);
                    ra[i]  <= ra[i] + (int'(ser_a) << cnt[i]);
                    rb[i]  <= rb[i] + (int'(ser_b) << cnt[i]);
                    cnt[i] <= cnt[i] + 1;
                    if (cnt[i] == 7) ph[i] <= 2;
                end else if (ph[i] == 2) begin
                    mres[i] <= {pa == pb, pa > pb, pa < pb};
                    ph[i]   <= 3;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d status", i), 32'(d_st[i]),
                    32'({1'b1, 1'b0, ph[i] == 2, ph[i] == 1 || ph[i] == 2, ph[i] == 3}));
                chk($sformatf("u%0d res", i), 32'(d_res[i]), 32'(mres[i]));
                if (ph[i] >= 2) begin
                    chk($sformatf("u%0d par_a", i), 32'(d_pa[i]), 32'(mpar(i, cnt[i], va[i], ra[i])));
                    chk($sformatf("u%0d par_b", i), 32'(d_pb[i]), 32'(mpar(i, cnt[i], vb[i], rb[i])));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_in();
        start = 1'b0; bit_valid = 1'b0; res_ack = 1'b0;
        ser_a = 1'b1; ser_b = 1'b0;   // junk that must be ignored
    endtask

    task automatic start_cycle(input logic ack);
        @(negedge clk);
        idle_in();
        start = 1'b1; res_ack = ack; bit_valid = 1'b1;  // bit_valid here must be ignored
    endtask

    // Streams the first nbits of a/b MSB-first; s1/s2 = bit index preceded by n1/n2 stall cycles.
    task automatic stream(input logic [7:0] a, input logic [7:0] b, input int nbits,
                          input int s1, input int n1, input int s2, input int n2, input int mid_start);
        for (int k = 0; k < nbits; k++) begin
            if (k == s1) repeat (n1) begin @(negedge clk); idle_in(); end
            if (k == s2) repeat (n2) begin @(negedge clk); idle_in(); end
            @(negedge clk);
            idle_in();
            start = (k == mid_start); bit_valid = 1'b1;
            ser_a = a[7-k]; ser_b = b[7-k];
        end
    endtask

    // Settle cycle then first done cycle, checked on the MSB-first instance.
    task automatic finish_load(input string nm, input logic [7:0] pa, input logic [7:0] pb,
                               input logic [2:0] res);
        @(negedge clk);
        idle_in();
        chk({nm, " settle opnd_valid/done"}, 32'({bus0.opnd_valid, bus0.done}), 32'b10);
        chk({nm, " settle par_a"}, 32'(bus0.par_a), 32'(pa));
        chk({nm, " settle par_b"}, 32'(bus0.par_b), 32'(pb));
        @(negedge clk);
        chk({nm, " done/opnd_valid"}, 32'({bus0.done, bus0.opnd_valid}), 32'b10);
        chk({nm, " res eq/gt/lt"}, 32'(d_res[0]), 32'(res));
    endtask

    task automatic ack_result(input string nm);
        @(negedge clk);
        idle_in(); res_ack = 1'b1;
        @(negedge clk);
        idle_in();
        chk({nm, " after ack busy/done"}, 32'({bus0.busy, bus0.done, bus1.busy, bus1.done}), 32'b0);
    endtask

    initial begin
        idle_in();
        repeat (2) @(negedge clk);
        chk("reset u0 outputs", 32'({bus0.par_a, bus0.par_b, d_st[0][2:0], d_res[0]}), 32'h0);
        chk("reset u1 outputs", 32'({bus1.par_a, bus1.par_b, d_st[1][2:0], d_res[1]}), 32'h0);
        rst_n = 1'b1;

        // 1: equal operands, no stalls; done held while no ack.
        start_cycle(1'b0);
        stream(8'hA5, 8'hA5, 8, -1, 0, -1, 0, -1);
        finish_load("t1", 8'hA5, 8'hA5, 3'b100);
        repeat (3) @(negedge clk);
        chk("t1 done held", 32'(bus0.done), 32'd1);
        ack_result("t1");

        // 2: A > B.
        start_cycle(1'b0);
        stream(8'h80, 8'h7F, 8, -1, 0, -1, 0, -1);
        finish_load("t2", 8'h80, 8'h7F, 3'b010);
        ack_result("t2");

        // 3: A < B with 2 stalls after bit 3 and 1 after bit 6: settle at cycle 12, done at 13.
        start_cycle(1'b0);
        stream(8'h03, 8'h04, 8, 3, 2, 6, 1, -1);
        finish_load("t3", 8'h03, 8'h04, 3'b001);
        ack_result("t3");

        // 4: start ignored mid-shift and in DONE without ack; then ack+start back-to-back.
        start_cycle(1'b0);
        stream(8'h3C, 8'h3D, 8, -1, 0, -1, 0, 4);
        finish_load("t4a", 8'h3C, 8'h3D, 3'b001);
        @(negedge clk);
        idle_in(); start = 1'b1;
        @(negedge clk);
        chk("t4 start w/o ack ignored", 32'({bus0.done, bus0.busy}), 32'b10);
        start_cycle(1'b1);
        @(negedge clk);
        idle_in();
        chk("t4 b2b busy", 32'(bus0.busy), 32'd1);
        chk("t4 b2b cleared", 32'({bus0.par_a, bus0.par_b, bus1.par_a, bus1.par_b}), 32'h0);
        stream(8'hC3, 8'h3C, 8, -1, 0, -1, 0, -1);
        finish_load("t4b", 8'hC3, 8'h3C, 3'b010);
        ack_result("t4b");

        // 5: asynchronous reset after 5 bits, then a fresh load.
        start_cycle(1'b0);
        stream(8'hFF, 8'h00, 5, -1, 0, -1, 0, -1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 reset u0", 32'({bus0.par_a, bus0.par_b, d_st[0][2:0], d_res[0]}), 32'h0);
        chk("t5 reset u1", 32'({bus1.par_a, bus1.par_b, d_st[1][2:0], d_res[1]}), 32'h0);
        @(negedge clk);
        idle_in();
        rst_n = 1'b1;
        start_cycle(1'b0);
        stream(8'h12, 8'h34, 8, -1, 0, -1, 0, -1);
        finish_load("t5", 8'h12, 8'h34, 3'b001);
        ack_result("t5");

        // 6: stream A = 1,0,...,0 and B = 0,...: LSB-first instance sees 0x01 vs 0x00.
        start_cycle(1'b0);
        stream(8'h80, 8'h00, 8, -1, 0, -1, 0, -1);
        finish_load("t6", 8'h80, 8'h00, 3'b010);
        chk("t6 lsb par_a", 32'(bus1.par_a), 32'h01);
        chk("t6 lsb par_b", 32'(bus1.par_b), 32'h00);
        chk("t6 lsb res", 32'(d_res[1]), 32'b010);
        ack_result("t6");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
